alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: XLEN, 32, operand/result width in bits (power of two, >= 8).
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request to run one operation; sampled only in IDLE.
REQ-005 func  input  4  operation code; passed unchanged to the bit-serial ALU.
REQ-006 op_a  input  XLEN  operand A; captured with start.
REQ-007 op_b  input  XLEN  operand B; captured with start.
REQ-008 busy  output  1  high in every non-IDLE state.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 result  output  XLEN  last completed result; held until the next completion.
REQ-011 alu_func  output  4  latched func to the 1-bit ALU.
REQ-012 alu_opA / alu_opB  output  1 each  current operand bits, LSB-first.
REQ-013 alu_carry_in  output  1  carry injection to the 1-bit ALU.
REQ-014 alu_rst  output  1  clears the ALU carry register.
REQ-015 alu_result  input  1  ALU result bit for the current operand bits.
REQ-016 alu_slt  input  1  registered ALU less-than flag.

Function
REQ-017 FSM states: IDLE, CLR, SHIFT, FIN; IDLE + start -> CLR; CLR -> SHIFT; SHIFT -> FIN after XLEN cycles; FIN -> IDLE.
REQ-018 On the accepting edge: func, op_a and op_b are latched into func_q, a_q and b_q; bit counter cleared.
REQ-019 start outside IDLE is ignored; no queuing; latched operands unchanged.
REQ-020 CLR lasts exactly one cycle; alu_rst = rst OR (state==CLR).
REQ-021 SHIFT: alu_opA=a_q[0], alu_opB=b_q[0]; each edge shifts a_q and b_q right by one and counter increments; exit when counter == XLEN-1.
REQ-022 alu_carry_in = func_q[3] during the first SHIFT cycle only, otherwise 0.
REQ-023 Each SHIFT edge: res_q <= {alu_result, res_q[XLEN-1:1]}.
REQ-024 FIN edge: if func_q[2:1]==2'b01 (SLT/SLTU), res_q <= zero-extended alu_slt; otherwise res_q unchanged.
REQ-025 done is registered high for the cycle after FIN, while state is IDLE; result=res_q is valid from that cycle.
REQ-026 Latency: start sampled at edge of cycle T -> done high in cycle T+XLEN+3 (T+35 for XLEN=32).
REQ-027 start coincident with done is accepted; result stays stable until the next FIN edge.
REQ-028 alu_func = func_q at all times; operand outputs are 0 outside SHIFT.

Reset
REQ-029 rst at any cycle, including mid-SHIFT: state=IDLE, busy=0, done=0, result=0, counter=0, a_q=b_q=0, alu_rst=1; no done pulse for the aborted operation.
REQ-030 First start after reset is accepted in the first cycle in which rst is low.

Structure
REQ-031 Shared package alu_seq_pkg holds: state enum (IDLE, CLR, SHIFT, FIN), XLEN default, func codes (ADD 0000, SUB 1000, SLT 1010, SLTU 1011, XOR 0100, OR 0110, AND 0111).
REQ-032 Single module, no sub-module; the 1-bit ALU is instantiated beside it in the parent, port-for-port.

Verification
REQ-033 Bench pairs alu_sequencer with the real 1-bit ALU and checks results against a reference model.
REQ-034 ADD 5+7 -> result 0x0000000C, done exactly 35 cycles after start.
REQ-035 SUB 3-5 -> 0xFFFFFFFE; then ADD 0xFFFFFFFF+1 -> 0x00000000, immediately followed by ADD 1+1 -> 0x00000002 (CLR removes the stale carry).
REQ-036 SLT 0xFFFFFFFF vs 0x00000001 -> 1; SLTU with the same operands -> 0.
REQ-037 start pulsed during cycles 5..20 of a busy ADD 10+20 -> single done, result 0x0000001E, operands not reloaded.
REQ-038 rst asserted at SHIFT cycle 16 -> IDLE next cycle, result 0, no done; a new ADD 2+2 then returns 0x00000004.

Source files
------------

// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_seq_pkg
//  Purpose  : Shared types and constants for the bit-serial ALU sequencer.
//             - state_t      : sequencer FSM states
//             - XLEN_DEFAULT : default operand / result width
//             - FUNC_*       : operation codes understood by the 1-bit ALU
//             - is_slt_func  : true for the compare operations (SLT / SLTU)
//  Revision : 1.0  initial release
// ============================================================================
package alu_seq_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLR   = 2'd1,
    SHIFT = 2'd2,
    FIN   = 2'd3
  } state_t;

  // func[3] selects subtraction (inverted B plus injected carry),
  // func[2:1] selects the result class, func[0] refines it.
  localparam logic [3:0] FUNC_ADD  = 4'b0000;
  localparam logic [3:0] FUNC_SUB  = 4'b1000;
  localparam logic [3:0] FUNC_SLT  = 4'b1010;
  localparam logic [3:0] FUNC_SLTU = 4'b1011;
  localparam logic [3:0] FUNC_XOR  = 4'b0100;
  localparam logic [3:0] FUNC_OR   = 4'b0110;
  localparam logic [3:0] FUNC_AND  = 4'b0111;

  function automatic logic is_slt_func(input logic [3:0] f);
    return (f[2:1] == 2'b01);
  endfunction

endpackage : alu_seq_pkg
`default_nettype wire

// File: rtl/alu_bit.sv
`default_nettype none
// ============================================================================
//  Module   : alu_bit
//  Purpose  : 1-bit serial ALU slice driven LSB-first by alu_sequencer.
//             Keeps a carry register between bits and a registered
//             less-than flag that reflects the most recent bit processed
//             (after the MSB it holds the final compare outcome).
//  Ports    : clk      in  clock
//             rst      in  synchronous active-high, clears carry and flag
//             func     in  [3:0] operation code
//             op_a     in  operand A bit
//             op_b     in  operand B bit
//             carry_in in  carry injection (first bit of a subtraction)
//             result   out combinational result bit
//             slt      out registered less-than flag
//  Revision : 1.0  initial release
// ============================================================================
module alu_bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] func,
  input  logic       op_a,
  input  logic       op_b,
  input  logic       carry_in,
  output logic       result,
  output logic       slt
);

  logic carry_q, carry_d;
  logic slt_q, slt_d;
  logic b_eff, c_eff, sum, cout;

  always_comb begin
    b_eff = op_b ^ func[3];
    c_eff = carry_q | carry_in;
    sum   = op_a ^ b_eff ^ c_eff;
    cout  = (op_a & b_eff) | (op_a & c_eff) | (b_eff & c_eff);

    case (func[2:1])
      2'b00, 2'b01: result = sum;
      2'b10:        result = op_a ^ op_b;
      default:      result = func[0] ? (op_a & op_b) : (op_a | op_b);
    endcase

    carry_d = cout;
    // Unsigned: borrow is the inverted carry out of A + ~B + 1.
    // Signed: sign of the difference corrected by overflow (cin ^ cout).
    slt_d   = func[0] ? ~cout : (sum ^ c_eff ^ cout);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      carry_q <= 1'b0;
      slt_q   <= 1'b0;
    end else begin
      carry_q <= carry_d;
      slt_q   <= slt_d;
    end
  end

  assign slt = slt_q;

endmodule : alu_bit
`default_nettype wire

// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : alu_sequencer
//  Purpose  : Runs one XLEN-bit operation through an external 1-bit ALU,
//             streaming operand bits LSB-first and collecting result bits.
//             IDLE -> CLR (clear ALU carry) -> SHIFT (XLEN cycles) -> FIN.
//  Ports    : clk, rst         clock, synchronous active-high reset
//             start            request; sampled only in IDLE
//             func, op_a, op_b operation and operands, captured with start
//             busy             high in every non-IDLE state
//             done             one-cycle pulse, result valid
//             result           last completed result, held until next one
//             alu_func         latched func to the 1-bit ALU
//             alu_opA/opB      current operand bits (0 outside SHIFT)
//             alu_carry_in     carry injection, first SHIFT cycle only
//             alu_rst          ALU carry clear (rst or CLR state)
//             alu_result       ALU result bit for the current operand bits
//             alu_slt          registered ALU less-than flag
//  Revision : 1.0  initial release
// ============================================================================
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [3:0]      func,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_func,
  output logic            alu_opA,
  output logic            alu_opB,
  output logic            alu_carry_in,
  output logic            alu_rst,
  input  logic            alu_result,
  input  logic            alu_slt
);

  localparam int            CW       = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  state_t          state_q, state_d;
  logic [3:0]      func_q, func_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            done_q, done_d;

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    a_d      = a_q;
    b_d      = b_q;
    res_d    = res_q;
    result_d = result_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLR;
          func_d  = func;
          a_d     = op_a;
          b_d     = op_b;
          cnt_d   = '0;
        end
      end
      CLR: begin
        state_d = SHIFT;
      end
      SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {alu_result, res_q[XLEN-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = FIN;
        end
      end
      FIN: begin
        // The compare flag was registered by the ALU on the last SHIFT edge.
        if (is_slt_func(func_q)) begin
          res_d    = {{(XLEN-1){1'b0}}, alu_slt};
          result_d = {{(XLEN-1){1'b0}}, alu_slt};
        end else begin
          result_d = res_q;
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      func_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_q    <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      func_q   <= func_d;
      a_q      <= a_d;
      b_q      <= b_d;
      res_q    <= res_d;
      result_q <= result_d;
      cnt_q    <= cnt_d;
      done_q   <= done_d;
    end
  end

  // result_q only moves on the FIN edge, so the visible result stays stable
  // while the shift register assembles the next one.
  assign busy         = (state_q != IDLE);
  assign done         = done_q;
  assign result       = result_q;
  assign alu_func     = func_q;
  assign alu_opA      = (state_q == SHIFT) ? a_q[0] : 1'b0;
  assign alu_opB      = (state_q == SHIFT) ? b_q[0] : 1'b0;
  assign alu_carry_in = (state_q == SHIFT) && (cnt_q == '0) && func_q[3];
  assign alu_rst      = rst | (state_q == CLR);

endmodule : alu_sequencer
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_sequencer
//  Purpose  : Self-checking bench pairing alu_sequencer with alu_bit and
//             comparing against an arithmetic reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;
  import alu_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  func;
  logic [31:0] op_a, op_b;
  logic        busy, done;
  logic [31:0] result;
  logic [3:0]  alu_func;
  logic        alu_opA, alu_opB, alu_carry_in, alu_rst, alu_result, alu_slt;

  int errors = 0;
  int checks = 0;

  alu_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .func(func), .op_a(op_a), .op_b(op_b),
    .busy(busy), .done(done), .result(result), .alu_func(alu_func),
    .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_carry_in(alu_carry_in),
    .alu_rst(alu_rst), .alu_result(alu_result), .alu_slt(alu_slt)
  );

  alu_bit u_alu (
    .clk(clk), .rst(alu_rst), .func(alu_func), .op_a(alu_opA), .op_b(alu_opB),
    .carry_in(alu_carry_in), .result(alu_result), .slt(alu_slt)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      FUNC_ADD:  return a + b;
      FUNC_SUB:  return a - b;
      FUNC_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      FUNC_SLTU: return (a < b) ? 32'd1 : 32'd0;
      FUNC_XOR:  return a ^ b;
      FUNC_OR:   return a | b;
      FUNC_AND:  return a & b;
      default:   return 32'd0;
    endcase
  endfunction

  // Issues start in the current cycle; lat = posedges from the accepting edge
  // (inclusive) until done is seen, -1 on timeout. held = result never moved
  // before done.
  task automatic run_op(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output int lat, output bit held);
    logic [31:0] prev;
    prev  = result;
    held  = 1'b1;
    lat   = -1;
    start = 1'b1; func = f; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c + 1;
        break;
      end
      if (result !== prev) held = 1'b0;
    end
    res = result;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; func = 4'd0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
    checks++; if (alu_rst !== 1'b1) begin errors++; $display("FAIL reset_alu_rst: got %b want 1", alu_rst); end
    checks++; if ({alu_opA, alu_opB, alu_carry_in} !== 3'b000)
      begin errors++; $display("FAIL reset_alu_ops: got %b want 000", {alu_opA, alu_opB, alu_carry_in}); end
  endtask

  // First start in the first cycle with rst low; ADD 5+7 with exact latency.
  task automatic test_add();
    logic [31:0] r; int lat; bit held;
    rst = 1'b0;
    run_op(FUNC_ADD, 32'd5, 32'd7, r, lat, held);
    checks++; if (lat != 35)         begin errors++; $display("FAIL add_latency: got %0d want 35", lat); end
    checks++; if (r !== 32'h0000000C) begin errors++; $display("FAIL add_result: got %h want 0000000c", r); end
    checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL add_busy_at_done: got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0)     begin errors++; $display("FAIL done_pulse_width: got %b want 0", done); end
    checks++; if (result !== 32'h0000000C) begin errors++; $display("FAIL result_hold: got %h want 0000000c", result); end
    checks++; if (alu_func !== FUNC_ADD)   begin errors++; $display("FAIL alu_func_idle: got %b want %b", alu_func, FUNC_ADD); end
  endtask

  // Bit streaming: operand bits LSB-first, carry injection on first bit only.
  task automatic test_stream();
    logic [31:0] a, b; bit bad; logic [31:0] r; int lat;
    a = $urandom; b = $urandom; bad = 1'b0;
    start = 1'b1; func = FUNC_SUB; op_a = a; op_b = b;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (busy !== 1'b1 || alu_rst !== 1'b1)
      begin errors++; $display("FAIL clr_state: busy=%b alu_rst=%b want 1 1", busy, alu_rst); end
    for (int k = 0; k < 32; k++) begin
      @(posedge clk); #1;
      if (alu_opA !== a[k] || alu_opB !== b[k] || alu_carry_in !== (k == 0) || alu_rst !== 1'b0) begin
        bad = 1'b1;
        $display("FAIL stream_bit%0d: got a=%b b=%b cin=%b rst=%b want a=%b b=%b cin=%b rst=0",
                 k, alu_opA, alu_opB, alu_carry_in, alu_rst, a[k], b[k], (k == 0));
      end
    end
    checks++; if (bad) errors++;
    lat = -1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      if (done) begin lat = c; break; end
    end
    r = result;
    checks++; if (lat != 1) begin errors++; $display("FAIL stream_done_pos: got %0d want 1", lat); end
    checks++; if (r !== a - b) begin errors++; $display("FAIL stream_result: got %h want %h", r, a - b); end
  endtask

  // SUB, carry-out ADD, then back-to-back ADD with start coincident with done.
  task automatic test_back_to_back();
    logic [31:0] r; int lat; bit held;
    run_op(FUNC_SUB, 32'd3, 32'd5, r, lat, held);
    checks++; if (r !== 32'hFFFFFFFE) begin errors++; $display("FAIL sub_result: got %h want fffffffe", r); end
    run_op(FUNC_ADD, 32'hFFFFFFFF, 32'd1, r, lat, held);
    checks++; if (r !== 32'h00000000) begin errors++; $display("FAIL add_wrap: got %h want 00000000", r); end
    checks++; if (!held) begin errors++; $display("FAIL result_stable_b2b: got changed want held"); end
    run_op(FUNC_ADD, 32'd1, 32'd1, r, lat, held);
    checks++; if (lat != 35)          begin errors++; $display("FAIL b2b_latency: got %0d want 35", lat); end
    checks++; if (r !== 32'h00000002) begin errors++; $display("FAIL add_after_carry: got %h want 00000002", r); end
  endtask

  task automatic test_slt();
    logic [31:0] r; int lat; bit held;
    run_op(FUNC_SLT, 32'hFFFFFFFF, 32'd1, r, lat, held);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL slt_result: got %h want 1", r); end
    run_op(FUNC_SLTU, 32'hFFFFFFFF, 32'd1, r, lat, held);
    checks++; if (r !== 32'd0) begin errors++; $display("FAIL sltu_result: got %h want 0", r); end
    run_op(FUNC_SLTU, 32'd1, 32'hFFFFFFFF, r, lat, held);
    checks++; if (r !== 32'd1) begin errors++; $display("FAIL sltu_less: got %h want 1", r); end
  endtask

  // start pulses while busy must be ignored.
  task automatic test_start_ignored();
    int ndone, lat; bit func_bad; logic [31:0] r;
    ndone = 0; lat = -1; func_bad = 1'b0; r = '0;
    start = 1'b1; func = FUNC_ADD; op_a = 32'd10; op_b = 32'd20;
    @(posedge clk); #1;
    for (int c = 1; c <= 60; c++) begin
      if (c >= 5 && c <= 20) begin
        start = 1'b1; func = FUNC_SUB; op_a = 32'h1234; op_b = 32'h99;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (busy && alu_func !== FUNC_ADD) func_bad = 1'b1;
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = c + 1; r = result; end
      end
    end
    func = FUNC_ADD; op_a = '0; op_b = '0;
    checks++; if (ndone != 1) begin errors++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    checks++; if (lat != 35)  begin errors++; $display("FAIL ignore_latency: got %0d want 35", lat); end
    checks++; if (r !== 32'h0000001E) begin errors++; $display("FAIL ignore_result: got %h want 0000001e", r); end
    checks++; if (func_bad) begin errors++; $display("FAIL ignore_func_reload: got reloaded want %b", FUNC_ADD); end
  endtask

  // Reset in SHIFT cycle 16 aborts the operation without a done pulse.
  task automatic test_mid_reset();
    logic [31:0] r; int lat, ndone; bit held;
    start = 1'b1; func = FUNC_ADD; op_a = 32'hAAAA5555; op_b = 32'h12345678;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (16) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL midrst_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0)    begin errors++; $display("FAIL midrst_done: got %b want 0", done); end
    checks++; if (result !== 32'd0) begin errors++; $display("FAIL midrst_result: got %h want 0", result); end
    checks++; if (alu_rst !== 1'b1) begin errors++; $display("FAIL midrst_alu_rst: got %b want 1", alu_rst); end
    rst = 1'b0;
    ndone = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done || busy) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_activity: got %0d want 0", ndone); end
    run_op(FUNC_ADD, 32'd2, 32'd2, r, lat, held);
    checks++; if (r !== 32'h00000004) begin errors++; $display("FAIL midrst_add: got %h want 00000004", r); end
  endtask

  task automatic test_random();
    logic [3:0] funcs [7];
    logic [3:0] f; logic [31:0] a, b, r, exp_r; int lat; bit held;
    funcs = '{FUNC_ADD, FUNC_SUB, FUNC_SLT, FUNC_SLTU, FUNC_XOR, FUNC_OR, FUNC_AND};
    for (int i = 0; i < 30; i++) begin
      f = funcs[$urandom_range(0, 6)];
      a = $urandom; b = $urandom;
      if (i % 5 == 0) b = a;
      exp_r = ref_alu(f, a, b);
      run_op(f, a, b, r, lat, held);
      checks++;
      if (r !== exp_r || lat != 35) begin
        errors++;
        $display("FAIL random_op%0d f=%b a=%h b=%h: got %h lat %0d want %h lat 35", i, f, a, b, r, lat, exp_r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_stream();
    test_back_to_back();
    test_slt();
    test_start_ignored();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_alu_sequencer
`default_nettype wire
